// File: rtl/item_fifo_pkg.sv
// Shared router types for the item buffer: item width, default depth and item typedef.
// SIZE is the router-wide item width and may already be set by the global defines.
`ifndef SIZE
`define SIZE 8
`endif

package item_fifo_pkg;

    localparam int ITEM_W        = `SIZE;
    localparam int DEFAULT_DEPTH = 4;

    typedef logic [ITEM_W-1:0] item_t;

endpackage

// File: rtl/item_fifo_mem.sv
// fifo_mem: DEPTH x ITEM_W register array with one synchronous write port and one
// asynchronous read port, so the head item is visible without an output register.
module fifo_mem
    import item_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [ITEM_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [ITEM_W-1:0] rd_data
);

    item_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/item_fifo.sv
// item_fifo: first-word-fall-through item buffer behind the receive arbiter, with an
// explicit occupancy counter and sticky overflow/underflow flags.
module item_fifo
    import item_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   write,
    input  logic [ITEM_W-1:0]      item_in,
    output logic                   full,
    output logic                   valid,
    output logic [ITEM_W-1:0]      item,
    input  logic                   read,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          push;
    logic          pop;
    logic          mem_wr_en;

    assign full  = (count == FULL_COUNT);
    assign valid = (count != '0);

    assign push = write & ~full;
    assign pop  = read & valid;

    // Reset wins over a concurrent push, so the array is not written on a reset edge.
    assign mem_wr_en = push & reset_n;

    fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (wp),
        .wr_data (item_in),
        .rd_addr (rp),
        .rd_data (item)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            // A simultaneous accepted push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (write && full) begin
                overflow <= 1'b1;
            end
            if (read && !valid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/item_fifo.md
# item_fifo

Per-port item buffer of the router datapath, sitting directly downstream of the receive arbiter. The arbiter's `write`/`full`/`item_out` drive this block's write side. The read side presents the same `valid`/`item`/`read` handshake that the arbiter and output stages consume. It is a synchronous first-word-fall-through FIFO of `SIZE`-bit items with occupancy reporting and sticky error flags.

## Interface
- `DEPTH`, 4: number of item slots; power of two, at least 2.
- `AW`, $clog2(DEPTH): pointer width; derived, never overridden.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `write`  in  1  push request; the item on `item_in` is stored at this edge.
- `item_in`  in  `SIZE`  item to push.
- `full`  out  1  high when count == DEPTH.
- `valid`  out  1  high when count != 0; head item is on `item`.
- `item`  out  `SIZE`  head item; stable while `valid` is high and `read` is low.
- `read`  in  1  pop request; the head is removed at this edge.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set by `write` while `full`.
- `underflow`  out  1  sticky; set by `read` while not `valid`.

## Operation
- Storage is DEPTH x `SIZE`, addressed by write pointer `wp` and read pointer `rp`, each AW bits.
- Pointers wrap modulo DEPTH with natural binary rollover.
- Occupancy is held in an explicit `count` register of AW+1 bits. `full` and `valid` are decoded combinationally from `count`.
- Accepted push: `write & !full`. Store `item_in` at `mem[wp]`, then `wp <= wp+1`.
- Accepted pop: `read & valid`. Then `rp <= rp+1`.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Simultaneous push and pop when full: `full` is high, so the push is rejected and `overflow` is set. The pop proceeds, and `count` becomes DEPTH−1.
- Simultaneous push and pop when empty: the pop is rejected and `underflow` is set. The push proceeds, and `count` becomes 1.
- Simultaneous push and pop when 0 < count < DEPTH: both are accepted and `count` is unchanged.
- Rejected operations never modify `mem`, `wp`, `rp` or `count`.
- `item` is a combinational read of `mem[rp]`. No output register, so a pushed item is visible as soon as `count` goes nonzero.
- `item` is don't-care while `valid` is low. The bench must not check it then.
- `overflow` and `underflow` stay set until reset.
- The state machine is implicit in `count`, with three conditions:
  - EMPTY (0)
  - PARTIAL (1..DEPTH−1)
  - FULL (DEPTH)
- Allowed transitions are ±1 per cycle only.

## Timing
- Reset values, applied on the edge where `reset_n` = 0:
  - `wp`, `rp`, `count` = 0
  - `valid` = 0, `full` = 0
  - `overflow` = 0, `underflow` = 0
- `mem` is not reset.
- Reset overrides any concurrent `write`/`read` on the same edge. In-flight contents are discarded.
- Write-to-valid latency: push at edge k gives `valid` = 1 and `item` = pushed value after edge k, i.e. visible in cycle k+1.
- Read-to-next-item latency: pop at edge k presents the next item (or `valid` = 0) in cycle k+1.
- Sustained throughput is one push and one pop per cycle.
- `full` is deasserted in the cycle after a pop from FULL. The upstream arbiter may push in that cycle.
- `read` may depend combinationally on `valid`. `write` may depend combinationally on `full`. The block has no combinational path from `write` or `read` to any output, except `item` via the `rp` update at the edge.

## Structure
- The `SIZE` item width comes from the shared global defines include used by the arbiter. No local redefinition.
- A shared router package holds the default DEPTH constant and the item typedef, if the team's typedef package is in use.
- One sub-module: `fifo_mem`, a DEPTH x `SIZE` register array with one synchronous write port and one asynchronous read port.
- Pointer, count and flag logic live in `item_fifo`.

## Test plan
- Reset, then push 0xA1, 0xB2, 0xC3 on consecutive cycles with `read` = 0:
  - `valid` rises the cycle after the first push.
  - `item` = 0xA1.
  - `count` = 3.
  - `full` = 0.
- Fill to DEPTH = 4, then hold `write` = 1 for one more cycle:
  - `full` = 1 and `count` = 4.
  - `overflow` = 1.
  - Contents unchanged; pops return the 4 original items in order.
- Steady state, count = 2, with `write` and `read` high for 10 cycles carrying 0x10..0x19:
  - `count` stays 2.
  - Output order matches input order.
  - Pointers wrap twice with no corruption.
- At `full` = 1, assert `read` and `write` together:
  - The pop succeeds and the push is rejected.
  - `count` = 3, `overflow` = 1.
  - Next cycle, a push succeeds and `count` = 4.
- Empty FIFO, assert `read` and `write`(0x55) together:
  - `underflow` = 1, `count` = 1.
  - `item` = 0x55 next cycle.
- Drive `reset_n` low for one edge with count = 3 and `write` = 1:
  - All outputs return to their reset values.
  - `count` = 0 and the flags clear.
  - A subsequent push/pop behaves as after power-up.
